// File: rtl/norm_shift_16bit.sv
// Two-stage normalizer: left-justifies a 16-bit significand using a precomputed
// leading-one index, adjusting the biased exponent and clamping into the denormal range.
module norm_shift_16bit #(
    parameter int EXP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [15:0]      i_mant,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [3:0]       i_pos_one,
    input  logic             i_zero_flag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      o_mant,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_zero,
    output logic             o_underflow
);

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_mant_q, s1_mant_d;
    logic [3:0]       s1_shift_q, s1_shift_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_uf_q, s1_uf_d;

    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      o_mant_q, o_mant_d;
    logic [EXP_W-1:0] o_exp_q, o_exp_d;
    logic             o_zero_q, o_zero_d;
    logic             o_uf_q, o_uf_d;

    logic             s2_adv;
    logic [3:0]       s_amt;
    logic [EXP_W-1:0] s_ext;

    always_comb begin
        s2_adv  = ~s2_valid_q | i_ready;
        o_ready = ~s1_valid_q | s2_adv;
        s_amt   = 4'd15 - i_pos_one;
        s_ext   = {{(EXP_W-4){1'b0}}, s_amt};

        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_shift_d = s1_shift_q;
        s1_exp_d   = s1_exp_q;
        s1_zero_d  = s1_zero_q;
        s1_uf_d    = s1_uf_q;

        s2_valid_d = s2_valid_q;
        o_mant_d   = o_mant_q;
        o_exp_d    = o_exp_q;
        o_zero_d   = o_zero_q;
        o_uf_d     = o_uf_q;

        if (o_ready) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                if (i_zero_flag) begin
                    s1_mant_d  = 16'd0;
                    s1_shift_d = 4'd0;
                    s1_exp_d   = '0;
                    s1_zero_d  = 1'b1;
                    s1_uf_d    = 1'b0;
                end else if (i_exp > s_ext) begin
                    s1_mant_d  = i_mant;
                    s1_shift_d = s_amt;
                    s1_exp_d   = i_exp - s_ext;
                    s1_zero_d  = 1'b0;
                    s1_uf_d    = 1'b0;
                end else begin
                    // i_exp <= 15 here, so its low nibble holds the whole value
                    s1_mant_d  = i_mant;
                    s1_shift_d = (i_exp == '0) ? 4'd0 : (i_exp[3:0] - 4'd1);
                    s1_exp_d   = '0;
                    s1_zero_d  = 1'b0;
                    s1_uf_d    = 1'b1;
                end
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_mant_d = s1_mant_q << s1_shift_q;
                o_exp_d  = s1_exp_q;
                o_zero_d = s1_zero_q;
                o_uf_d   = s1_uf_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= 16'd0;
            s1_shift_q <= 4'd0;
            s1_exp_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_uf_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            o_mant_q   <= 16'd0;
            o_exp_q    <= '0;
            o_zero_q   <= 1'b0;
            o_uf_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_shift_q <= s1_shift_d;
            s1_exp_q   <= s1_exp_d;
            s1_zero_q  <= s1_zero_d;
            s1_uf_q    <= s1_uf_d;
            s2_valid_q <= s2_valid_d;
            o_mant_q   <= o_mant_d;
            o_exp_q    <= o_exp_d;
            o_zero_q   <= o_zero_d;
            o_uf_q     <= o_uf_d;
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_mant      = o_mant_q;
    assign o_exp       = o_exp_q;
    assign o_zero      = o_zero_q;
    assign o_underflow = o_uf_q;

endmodule

// File: tb/tb_norm_shift_16bit.sv
// Bench for norm_shift_16bit: fixed vectors, backpressure/reset sequences and
// randomized traffic scored against an arithmetic model.
module tb_norm_shift_16bit;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_ready, i_zero_flag;
    logic [15:0] i_mant;
    logic [7:0]  i_exp;
    logic [3:0]  i_pos_one;
    logic        o_ready, o_valid, o_zero, o_underflow;
    logic [15:0] o_mant;
    logic [7:0]  o_exp;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    norm_shift_16bit #(.EXP_W(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mant     (i_mant),
        .i_exp      (i_exp),
        .i_pos_one  (i_pos_one),
        .i_zero_flag(i_zero_flag),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_mant     (o_mant),
        .o_exp      (o_exp),
        .o_zero     (o_zero),
        .o_underflow(o_underflow)
    );

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        uf;
    } res_t;

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic [3:0]  pos;
        logic        zf;
        logic [15:0] e_mant;
        logic [7:0]  e_exp;
        logic        e_zero;
        logic        e_uf;
    } vec_t;

    res_t sb_q[$];

    // Reference: value scaled by a power of two, exponent lowered by the same amount
    function automatic res_t ref_model(input logic [15:0] m, input logic [7:0] e,
                                       input logic [3:0] p, input logic z);
        res_t r;
        int   s, sh, scaled;
        s = 15 - int'(p);
        if (z) begin
            r.mant = 16'd0; r.exp = 8'd0; r.zero = 1'b1; r.uf = 1'b0;
            return r;
        end
        if (int'(e) > s) begin
            sh = s;
            r.exp = 8'(int'(e) - s);
            r.uf = 1'b0;
        end else begin
            sh = (int'(e) == 0) ? 0 : int'(e) - 1;
            r.exp = 8'd0;
            r.uf = 1'b1;
        end
        scaled = (int'(m) * (2 ** sh)) % 65536;
        r.mant = 16'(scaled);
        r.zero = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: drive at negedge, score the transfers that the next posedge performs
    task automatic cycle(input logic v, input logic r, input logic [15:0] m,
                         input logic [7:0] e, input logic [3:0] p, input logic z);
        res_t want;
        @(negedge clk);
        i_valid = v; i_ready = r; i_mant = m; i_exp = e; i_pos_one = p; i_zero_flag = z;
        #1;
        check("o_ready", {31'd0, o_ready}, {31'd0, !(sb_q.size() == 2 && !r)});
        if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                want = sb_q.pop_front();
                check("mant", {16'd0, o_mant}, {16'd0, want.mant});
                check("exp", {24'd0, o_exp}, {24'd0, want.exp});
                check("zero", {31'd0, o_zero}, {31'd0, want.zero});
                check("underflow", {31'd0, o_underflow}, {31'd0, want.uf});
                $display("beat out: mant=%04h exp=%0d zero=%0b uf=%0b", o_mant, o_exp, o_zero, o_underflow);
            end
        end
        if (i_valid && o_ready) sb_q.push_back(ref_model(m, e, p, z));
    endtask

    vec_t vecs[9];
    res_t ra;

    initial begin
        vecs[0] = '{16'h0100, 8'd20,   4'd8,  1'b0, 16'h8000, 8'd13,  1'b0, 1'b0};
        vecs[1] = '{16'hA5A5, 8'd1,    4'd15, 1'b0, 16'hA5A5, 8'd1,   1'b0, 1'b0};
        vecs[2] = '{16'h0010, 8'd5,    4'd4,  1'b0, 16'h0100, 8'd0,   1'b0, 1'b1};
        vecs[3] = '{16'h0010, 8'd0,    4'd4,  1'b0, 16'h0010, 8'd0,   1'b0, 1'b1};
        vecs[4] = '{16'h0000, 8'h7F,   4'd0,  1'b1, 16'h0000, 8'd0,   1'b1, 1'b0};
        vecs[5] = '{16'h0001, 8'd15,   4'd0,  1'b0, 16'h4000, 8'd0,   1'b0, 1'b1};
        vecs[6] = '{16'h0001, 8'd16,   4'd0,  1'b0, 16'h8000, 8'd1,   1'b0, 1'b0};
        vecs[7] = '{16'h00FF, 8'd200,  4'd7,  1'b0, 16'hFF00, 8'd192, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 8'hFF,   4'd9,  1'b1, 16'h0000, 8'd0,   1'b1, 1'b0};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_mant = 16'd0; i_exp = 8'd0; i_pos_one = 4'd0; i_zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_mant", {16'd0, o_mant}, 32'd0);
        check("rst_exp", {24'd0, o_exp}, 32'd0);
        check("rst_zero", {31'd0, o_zero}, 32'd0);
        check("rst_uf", {31'd0, o_underflow}, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);

        // Fixed vectors with exact two-cycle latency
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, 1'b1, vecs[k].mant, vecs[k].exp, vecs[k].pos, vecs[k].zf);
            cycle(1'b0, 1'b1, 16'd0, 8'd0, 4'd0, 1'b0);
            check("lat_not_yet", {31'd0, o_valid}, 32'd0);
            @(negedge clk);
            #1;
            check("lat_valid", {31'd0, o_valid}, 32'd1);
            check("vec_mant", {16'd0, o_mant}, {16'd0, vecs[k].e_mant});
            check("vec_exp", {24'd0, o_exp}, {24'd0, vecs[k].e_exp});
            check("vec_zero", {31'd0, o_zero}, {31'd0, vecs[k].e_zero});
            check("vec_uf", {31'd0, o_underflow}, {31'd0, vecs[k].e_uf});
            $display("vector %0d: mant=%04h exp=%0d zero=%0b uf=%0b", k, o_mant, o_exp, o_zero, o_underflow);
            void'(sb_q.pop_front());
        end
        i_valid = 1'b0;
        cycle(1'b0, 1'b1, 16'd0, 8'd0, 4'd0, 1'b0);
        check("vec_drained", {31'd0, o_valid}, 32'd0);

        // Backpressure: A, B fill the pipe, C is refused until i_ready rises
        ra = ref_model(16'h0100, 8'd20, 4'd8, 1'b0);
        cycle(1'b1, 1'b0, 16'h0100, 8'd20, 4'd8, 1'b0);
        cycle(1'b1, 1'b0, 16'h0010, 8'd5, 4'd4, 1'b0);
        cycle(1'b1, 1'b0, 16'h00FF, 8'd200, 4'd7, 1'b0);
        check("bp_full", {31'd0, o_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 16'h00FF, 8'd200, 4'd7, 1'b0);
            check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp_hold_mant", {16'd0, o_mant}, {16'd0, ra.mant});
            check("bp_hold_exp", {24'd0, o_exp}, {24'd0, ra.exp});
        end
        cycle(1'b1, 1'b1, 16'h00FF, 8'd200, 4'd7, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 16'd0, 8'd0, 4'd0, 1'b0);
        check("bp_all_out", sb_q.size(), 32'd0);

        // Reset with two beats in flight
        cycle(1'b1, 1'b0, 16'h0100, 8'd20, 4'd8, 1'b0);
        cycle(1'b1, 1'b0, 16'hA5A5, 8'd1, 4'd15, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        check("mid_inflight", {31'd0, o_valid}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_mant", {16'd0, o_mant}, 32'd0);
        check("mid_rst_exp", {24'd0, o_exp}, 32'd0);
        check("mid_rst_zero", {31'd0, o_zero}, 32'd0);
        check("mid_rst_uf", {31'd0, o_underflow}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, o_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 16'd0, 8'd0, 4'd0, 1'b0);
            check("no_stale", {31'd0, o_valid}, 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            logic        v, r, z;
            logic [3:0]  p;
            logic [7:0]  e;
            logic [15:0] m, lowmask;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            z = ($urandom_range(0, 9) == 0);
            p = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
            lowmask = 16'((32'd1 << p) - 32'd1);
            m = (16'd1 << p) | (16'($urandom) & lowmask);
            if (z) m = 16'd0;
            cycle(v, r, m, e, p, z);
        end
        for (int k = 0; k < 10 && sb_q.size() != 0; k++)
            cycle(1'b0, 1'b1, 16'd0, 8'd0, 4'd0, 1'b0);
        check("drain_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
